// File: rtl/wb_stage_if.sv
// MEM/WB pipeline-register bundle feeding the writeback stage; combinational, no handshake,
// holds stable while the pipeline is stalled.
interface wb_stage_if;
   logic [31:0] wb_pc;
   logic [31:0] wb_inst;
   logic [31:0] wb_res;
   logic        wb_load;
   logic        wb_al;
   logic        wb_regwen;
   logic        wb_eret;
   logic        wb_cp0ren;
   logic [4:0]  wb_wreg;
   logic [31:0] wb_cp0rdata;
   logic [31:0] wb_hilordata;
   logic [1:0]  wb_hiloren;
   logic [1:0]  wb_hilowen;
   logic [63:0] wb_hilowdata;
   logic [31:0] data_sram_rdata;

   modport master (
      output wb_pc, wb_inst, wb_res, wb_load, wb_al, wb_regwen, wb_eret, wb_cp0ren,
             wb_wreg, wb_cp0rdata, wb_hilordata, wb_hiloren, wb_hilowen, wb_hilowdata,
             data_sram_rdata
   );

   modport slave (
      input  wb_pc, wb_inst, wb_res, wb_load, wb_al, wb_regwen, wb_eret, wb_cp0ren,
             wb_wreg, wb_cp0rdata, wb_hilordata, wb_hiloren, wb_hilowen, wb_hilowdata,
             data_sram_rdata
   );
endinterface

// File: rtl/wb_stage.sv
// MIPS writeback: commits each instruction once (GPR port, HI/LO, retire count, debug trace).
// GPR/debug outputs combinational; HI/LO and retire_cnt visible the cycle after commit; stall-safe.
module wb_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        refresh,
   wb_stage_if.slave   wb,
   output logic        rf_wen,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        eret_commit,
   output logic [31:0] retire_cnt,
   output logic [31:0] debug_wb_pc,
   output logic [3:0]  debug_wb_rf_wen,
   output logic [4:0]  debug_wb_rf_wnum,
   output logic [31:0] debug_wb_rf_wdata
);

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;

   logic        done;
   logic        valid;
   logic        fire;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_data;
   logic        unused_inst;

   assign unused_inst = ^wb.wb_inst[25:0];

   // done remembers that the held instruction already committed during this stall
   assign valid = (wb.wb_pc != 32'd0);
   assign fire  = valid & ~done & ~refresh & ~reset;

   always_comb begin
      ld_byte = wb.data_sram_rdata[7:0];
      case (wb.wb_res[1:0])
         2'd0: ld_byte = wb.data_sram_rdata[7:0];
         2'd1: ld_byte = wb.data_sram_rdata[15:8];
         2'd2: ld_byte = wb.data_sram_rdata[23:16];
         2'd3: ld_byte = wb.data_sram_rdata[31:24];
         default: ld_byte = wb.data_sram_rdata[7:0];
      endcase
      ld_half = wb.wb_res[1] ? wb.data_sram_rdata[31:16] : wb.data_sram_rdata[15:0];
      case (wb.wb_inst[31:26])
         OP_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
         OP_LBU:  load_data = {24'd0, ld_byte};
         OP_LH:   load_data = {{16{ld_half[15]}}, ld_half};
         OP_LHU:  load_data = {16'd0, ld_half};
         default: load_data = wb.data_sram_rdata;
      endcase
   end

   always_comb begin
      if (wb.wb_load)
         rf_wdata = load_data;
      else if (wb.wb_cp0ren)
         rf_wdata = wb.wb_cp0rdata;
      else if (|wb.wb_hiloren)
         rf_wdata = wb.wb_hilordata;
      else if (wb.wb_al)
         rf_wdata = wb.wb_pc + 32'd8;
      else
         rf_wdata = wb.wb_res;
   end

   assign rf_wen      = fire & wb.wb_regwen & (wb.wb_wreg != 5'd0);
   assign rf_waddr    = wb.wb_wreg;
   assign eret_commit = fire & wb.wb_eret;

   assign debug_wb_pc       = wb.wb_pc;
   assign debug_wb_rf_wen   = {4{rf_wen}};
   assign debug_wb_rf_wnum  = rf_waddr;
   assign debug_wb_rf_wdata = rf_wdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         hi         <= 32'd0;
         lo         <= 32'd0;
         retire_cnt <= 32'd0;
         done       <= 1'b0;
      end else begin
         if (fire) begin
            retire_cnt <= retire_cnt + 32'd1;
            case (wb.wb_hilowen)
               2'b11:   {hi, lo} <= wb.wb_hilowdata;
               2'b10:   hi <= wb.wb_res;
               2'b01:   lo <= wb.wb_res;
               default: ;
            endcase
         end
         done <= stall ? (done | fire) : 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed literal checks plus a randomized run scored every cycle against
// an instruction-level model of commit, load formatting, HI/LO and the retire counter.
module tb_wb_stage;
   logic        clk;
   logic        reset;
   logic        stall;
   logic        refresh;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        eret_commit;
   logic [31:0] retire_cnt;
   logic [31:0] debug_wb_pc;
   logic [3:0]  debug_wb_rf_wen;
   logic [4:0]  debug_wb_rf_wnum;
   logic [31:0] debug_wb_rf_wdata;

   wb_stage_if bus ();

   wb_stage dut (
      .clk               (clk),
      .reset             (reset),
      .stall             (stall),
      .refresh           (refresh),
      .wb                (bus),
      .rf_wen            (rf_wen),
      .rf_waddr          (rf_waddr),
      .rf_wdata          (rf_wdata),
      .hi                (hi),
      .lo                (lo),
      .eret_commit       (eret_commit),
      .retire_cnt        (retire_cnt),
      .debug_wb_pc       (debug_wb_pc),
      .debug_wb_rf_wen   (debug_wb_rf_wen),
      .debug_wb_rf_wnum  (debug_wb_rf_wnum),
      .debug_wb_rf_wdata (debug_wb_rf_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model state: architectural HI/LO, retire count, and whether the instruction
   // currently parked in WB has already been committed during its stall
   logic [31:0] m_hi = 0, m_lo = 0;
   int unsigned m_cnt = 0;
   bit          m_committed = 0;

   function automatic logic [31:0] model_wdata();
      logic [31:0] b, h;
      b = (bus.data_sram_rdata >> (8 * bus.wb_res[1:0])) & 32'hFF;
      h = (bus.data_sram_rdata >> (16 * bus.wb_res[1])) & 32'hFFFF;
      if (bus.wb_load) begin
         case (bus.wb_inst[31:26])
            6'b100000: return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
            6'b100100: return b;
            6'b100001: return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
            6'b100101: return h;
            default:   return bus.data_sram_rdata;
         endcase
      end
      if (bus.wb_cp0ren) return bus.wb_cp0rdata;
      if (bus.wb_hiloren != 2'b00) return bus.wb_hilordata;
      if (bus.wb_al) return bus.wb_pc + 32'd8;
      return bus.wb_res;
   endfunction

   always @(negedge clk) begin
      bit          e_fire, e_wen;
      logic [31:0] e_wdata;
      if (chk_en) begin
         e_fire  = !reset && bus.wb_pc != 0 && !refresh && !m_committed;
         e_wen   = e_fire && bus.wb_regwen && bus.wb_wreg != 0;
         e_wdata = model_wdata();
         check("rf_wen", rf_wen, e_wen);
         check("rf_waddr", rf_waddr, bus.wb_wreg);
         check("rf_wdata", rf_wdata, e_wdata);
         check("eret_commit", eret_commit, e_fire && bus.wb_eret);
         check("hi", hi, m_hi);
         check("lo", lo, m_lo);
         check("retire_cnt", retire_cnt, m_cnt);
         check("dbg_pc", debug_wb_pc, bus.wb_pc);
         check("dbg_wen", debug_wb_rf_wen, e_wen ? 4'hF : 4'h0);
         check("dbg_wnum", debug_wb_rf_wnum, bus.wb_wreg);
         check("dbg_wdata", debug_wb_rf_wdata, e_wdata);
         if (reset) begin
            m_hi = 0; m_lo = 0; m_cnt = 0; m_committed = 0;
         end else begin
            if (e_fire) begin
               m_cnt++;
               if (bus.wb_hilowen == 2'b11) {m_hi, m_lo} = bus.wb_hilowdata;
               else if (bus.wb_hilowen == 2'b10) m_hi = bus.wb_res;
               else if (bus.wb_hilowen == 2'b01) m_lo = bus.wb_res;
            end
            m_committed = stall && (m_committed || e_fire);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      bus.wb_pc = 0; bus.wb_inst = 0; bus.wb_res = 0; bus.wb_load = 0; bus.wb_al = 0;
      bus.wb_regwen = 0; bus.wb_eret = 0; bus.wb_cp0ren = 0; bus.wb_wreg = 0;
      bus.wb_cp0rdata = 0; bus.wb_hilordata = 0; bus.wb_hiloren = 0; bus.wb_hilowen = 0;
      bus.wb_hilowdata = 0; bus.data_sram_rdata = 0;
   endtask

   task automatic rand_instr();
      logic [5:0] ops [6];
      ops = '{6'b100000, 6'b100100, 6'b100001, 6'b100101, 6'b100011, 6'b000000};
      bus.wb_pc = ($urandom_range(0, 5) == 0) ? 32'd0 : {$urandom() >> 2, 2'b00};
      bus.wb_inst = {($urandom_range(0, 3) == 0) ? 6'($urandom()) : ops[$urandom_range(0, 5)],
                     26'($urandom())};
      bus.wb_res = $urandom();
      bus.wb_load = ($urandom_range(0, 2) == 0);
      bus.wb_al = ($urandom_range(0, 4) == 0);
      bus.wb_regwen = ($urandom_range(0, 3) != 0);
      bus.wb_wreg = 5'($urandom());
      bus.wb_eret = ($urandom_range(0, 9) == 0);
      bus.wb_cp0ren = ($urandom_range(0, 7) == 0);
      bus.wb_hiloren = ($urandom_range(0, 5) == 0) ? 2'($urandom()) : 2'b00;
      bus.wb_hilowen = ($urandom_range(0, 2) == 0) ? 2'($urandom()) : 2'b00;
      bus.wb_hilowdata = {$urandom(), $urandom()};
      bus.wb_cp0rdata = $urandom();
      bus.wb_hilordata = $urandom();
      bus.data_sram_rdata = $urandom();
   endtask

   initial begin
      bit prev_stall, prev_reset;
      reset = 1; stall = 0; refresh = 0;
      clr();
      bus.wb_pc = 32'h400; bus.wb_regwen = 1; bus.wb_wreg = 7; bus.wb_eret = 1;
      bus.wb_hilowen = 2'b11; bus.wb_hilowdata = 64'h1234_5678_9ABC_DEF0; bus.wb_res = 32'h55;
      tick();
      chk_en = 1;
      repeat (2) begin
         @(negedge clk);
         check("rst_rf_wen", rf_wen, 0);
         check("rst_eret", eret_commit, 0);
         check("rst_hi", hi, 0);
         check("rst_lo", lo, 0);
         check("rst_cnt", retire_cnt, 0);
         tick();
      end
      reset = 0; clr();
      @(negedge clk); tick();
      @(negedge clk); check("bubble_cnt", retire_cnt, 0);

      tick();
      bus.wb_pc = 32'h100; bus.wb_load = 1; bus.wb_regwen = 1; bus.wb_wreg = 3;
      bus.wb_inst = {6'b100000, 26'd0}; bus.wb_res = 32'h1003; bus.data_sram_rdata = 32'h80FF1234;
      @(negedge clk); check("lb_data", rf_wdata, 32'hFFFFFF80); check("lb_wen", rf_wen, 1);
      tick();
      bus.wb_pc = 32'h104; bus.wb_inst = {6'b100101, 26'd0}; bus.wb_res = 32'h1002;
      @(negedge clk); check("lhu_data", rf_wdata, 32'h000080FF);
      tick();
      bus.wb_pc = 32'h108; bus.wb_inst = {6'b100011, 26'd0}; bus.wb_res = 32'h1000;
      @(negedge clk); check("lw_data", rf_wdata, 32'h80FF1234);

      tick();
      clr();
      bus.wb_pc = 32'h10C; bus.wb_inst = 32'h00A00021; bus.wb_res = 32'h2A;
      bus.wb_regwen = 1; bus.wb_wreg = 5; stall = 1;
      @(negedge clk); check("stall_c1_wen", rf_wen, 1); check("stall_c1_data", rf_wdata, 32'h2A);
      tick(); @(negedge clk); check("stall_c2_wen", rf_wen, 0);
      tick(); @(negedge clk); check("stall_c3_wen", rf_wen, 0);
      tick(); stall = 0; clr();
      @(negedge clk); check("stall_cnt", retire_cnt, 4);

      tick();
      bus.wb_pc = 32'h200; bus.wb_inst = 32'h00850018; bus.wb_hilowen = 2'b11;
      bus.wb_hilowdata = 64'h00000001_FFFFFFFE;
      @(negedge clk); check("mult_wen", rf_wen, 0);
      tick();
      clr();
      bus.wb_pc = 32'h204; bus.wb_inst = 32'h00800011; bus.wb_hilowen = 2'b10; bus.wb_res = 7;
      @(negedge clk); check("mult_hi", hi, 1); check("mult_lo", lo, 32'hFFFFFFFE);
      tick(); clr();
      @(negedge clk); check("mthi_hi", hi, 7); check("mthi_lo", lo, 32'hFFFFFFFE);

      tick();
      bus.wb_pc = 32'hBFC00010; bus.wb_inst = {6'b000011, 26'd0}; bus.wb_al = 1;
      bus.wb_regwen = 1; bus.wb_wreg = 31; refresh = 1;
      @(negedge clk); check("jal_ref_wen", rf_wen, 0); check("jal_link", rf_wdata, 32'hBFC00018);
      tick(); refresh = 0;
      @(negedge clk); check("jal_ref_cnt", retire_cnt, 6); check("jal_wen", rf_wen, 1);

      tick(); clr();
      bus.wb_pc = 32'hBFC00380; bus.wb_inst = 32'h42000018; bus.wb_eret = 1; stall = 1;
      @(negedge clk); check("eret_pulse", eret_commit, 1);
      tick(); @(negedge clk); check("eret_held", eret_commit, 0);
      tick(); stall = 0; clr();
      @(negedge clk); check("eret_after", eret_commit, 0); check("eret_cnt", retire_cnt, 8);

      tick();
      bus.wb_pc = 32'h300; bus.wb_regwen = 1; bus.wb_wreg = 0; bus.wb_res = 32'hDEAD;
      @(negedge clk); check("r0_wen", rf_wen, 0);
      tick(); clr();
      @(negedge clk); check("r0_cnt", retire_cnt, 9);

      prev_stall = 0; prev_reset = 0;
      for (int i = 0; i < 4000; i++) begin
         tick();
         if (!(prev_stall && !prev_reset)) rand_instr();
         reset = ($urandom_range(0, 49) == 0);
         stall = ($urandom_range(0, 2) == 0);
         refresh = ($urandom_range(0, 9) == 0);
         prev_stall = stall;
         prev_reset = reset;
      end
      tick();
      reset = 0; stall = 0; refresh = 0; clr();
      @(negedge clk);
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the five-stage MIPS pipeline, fed directly by the MEM/WB pipeline register outputs. Commits each instruction exactly once: formats load data, selects the register-file write value, drives the GPR write port and debug trace, and owns the architectural HI/LO registers. Guarantees single commit across stalls, suppresses commit on refresh, and counts retired instructions.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  pipeline stall; WB inputs held stable while high
- refresh  in  1  pipeline flush; instruction currently in WB must not commit
- wb_pc, wb_inst, wb_res  in  32 each  PC, instruction word, ALU result or effective address
- wb_load, wb_al, wb_regwen, wb_eret, wb_cp0ren  in  1 each  load, link, GPR write enable, ERET, CP0 read
- wb_wreg  in  5  destination GPR
- wb_cp0rdata, wb_hilordata  in  32 each  CP0 read data; HI/LO read data for MFHI/MFLO
- wb_hiloren, wb_hilowen  in  2 each  bit1 = HI, bit0 = LO
- wb_hilowdata  in  64  {HI,LO} result for MULT/DIV (both wen bits set)
- data_sram_rdata  in  32  load data word for the instruction in WB
- rf_wen  out  1; rf_waddr  out  5; rf_wdata  out  32  GPR write port
- hi, lo  out  32 each  architectural HI/LO
- eret_commit  out  1  one-cycle pulse when ERET commits
- retire_cnt  out  32  committed-instruction count
- debug_wb_pc  out  32; debug_wb_rf_wen  out  4; debug_wb_rf_wnum  out  5; debug_wb_rf_wdata  out  32

## Operation
- valid = (wb_pc != 0); bubbles from reset/refresh of MEM/WB are all-zero.
- done: internal flag, set when an instruction fires while stall is high.
- fire = valid & !done & !refresh.
- done next state: reset -> 0; else stall -> done | fire; else 0.
- rf_wen = fire & wb_regwen & (wb_wreg != 0); rf_waddr = wb_wreg.
- rf_wdata priority: wb_load -> formatted load; wb_cp0ren -> wb_cp0rdata; |wb_hiloren -> wb_hilordata; wb_al -> wb_pc + 8 (mod 2^32); else wb_res.
- Load formatting by opcode wb_inst[31:26], byte offset a = wb_res[1:0], little-endian:
  - LB 100000: sign-extend byte a; LBU 100100: zero-extend byte a.
  - LH 100001: sign-extend halfword wb_res[1]; LHU 100101: zero-extend.
  - LW 100011 and any other opcode: full word.
- HI/LO, on fire only: hilowen 2'b11 -> {hi,lo} <= wb_hilowdata; 2'b10 -> hi <= wb_res; 2'b01 -> lo <= wb_res.
- eret_commit = fire & wb_eret.
- retire_cnt increments by 1 on each fire; wraps 0xFFFFFFFF -> 0.
- Debug: debug_wb_pc = wb_pc; debug_wb_rf_wen = {4{rf_wen}}; debug_wb_rf_wnum = rf_waddr; debug_wb_rf_wdata = rf_wdata.

## Timing
- Reset values: hi = 0, lo = 0, retire_cnt = 0, done = 0. In the reset cycle rf_wen = 0 and eret_commit = 0 regardless of inputs.
- rf_*, eret_commit, debug_*: combinational, same cycle as the WB inputs.
- hi/lo and retire_cnt update on the clock edge ending the fire cycle; visible next cycle.
- Stalled instruction: fires in its first WB cycle only; held cycles produce rf_wen = 0. The first cycle after stall deasserts also has done = 0, so the next instruction fires normally.
- refresh and stall both high: no fire; done unchanged.
- refresh while done = 1: no effect; the commit already happened.
- Reset mid-stall clears done. The held instruction recommits after reset, but upstream MEM/WB is also reset, so it is a bubble.
- wb_wreg = 0 with wb_regwen = 1: no GPR write, but the instruction still retires.

## Test plan
- Reset held 2 cycles with nonzero inputs -> hi = lo = retire_cnt = 0, rf_wen = 0; release with bubble -> retire_cnt stays 0.
- LB, wb_res = 0x1003, data 0x80FF1234 -> rf_wdata = 0xFFFFFF80. LHU, wb_res = 0x1002, same data -> 0x000080FF. LW -> 0x80FF1234.
- ADDU to $5 (res 0x2A), stall high 3 cycles -> rf_wen high only in the first cycle; retire_cnt +1 exactly.
- MULT with hilowen = 11 and hilowdata = 0x00000001_FFFFFFFE -> next cycle hi = 1, lo = 0xFFFFFFFE, rf_wen = 0. MTHI with res 7 -> hi = 7, lo unchanged.
- JAL at pc 0xBFC00010, wreg 31 -> rf_wdata = 0xBFC00018. Same cycle with refresh = 1 -> rf_wen = 0, retire_cnt unchanged.
- ERET fires -> eret_commit single-cycle pulse. Preload retire_cnt to 0xFFFFFFFF via fires, one more fire -> 0.
